// File: rtl/gate_model_bist_if.sv
// Port bundle between the gate-model BIST driver and its controller/model side.
// The slave modport is the BIST block; the master modport is whoever drives it.
interface gate_model_bist_if #(
  parameter int IN_W  = 17,
  parameter int OUT_W = 9
);
  logic             start;
  logic             abort;
  logic             step;
  logic [OUT_W-1:0] resp;
  logic [IN_W-1:0]  stim;
  logic             busy;
  logic             done;
  logic             pass;
  logic [15:0]      signature;

  modport slave (
    input  start, abort, step, resp,
    output stim, busy, done, pass, signature
  );

  modport master (
    output start, abort, step, resp,
    input  stim, busy, done, pass, signature
  );
endinterface

// File: rtl/gate_model_bist.sv
// LFSR stimulus generator plus 16-bit MISR compactor for combinational gate models.
// Optional macro GATE_BIST_STEP_EN: RUN advances only on edges where step=1.
module gate_model_bist #(
  parameter int              IN_W     = 17,
  parameter int              OUT_W    = 9,
  parameter int              PATTERNS = 256,
  parameter logic [IN_W-1:0] SEED     = 17'h00001,
  parameter logic [15:0]     EXPECTED = 16'h0000
) (
  input  logic               clk,
  input  logic               rst,
  gate_model_bist_if.slave   bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // An all-zero seed would lock the LFSR, so it is forced to 1.
  localparam logic [IN_W-1:0] SEED_EFF = (SEED == '0) ? IN_W'(1) : SEED;
  localparam logic [15:0]     LAST_CNT = 16'(PATTERNS - 1);

  logic [1:0]      r_state;
  logic [15:0]     r_count;
  logic [IN_W-1:0] r_stim;
  logic [15:0]     r_sig;
  logic            r_busy;
  logic            r_done;
  logic            r_pass;

  logic [15:0]     w_sig_next;
  logic [IN_W-1:0] w_stim_next;
  logic            w_advance;

  assign w_sig_next  = {r_sig[14:0], 1'b0}
                     ^ (r_sig[15] ? 16'h8005 : 16'h0000)
                     ^ 16'(bus.resp);
  assign w_stim_next = {r_stim[IN_W-2:0], r_stim[IN_W-1] ^ r_stim[IN_W-4]};

`ifdef GATE_BIST_STEP_EN
  assign w_advance = bus.step;
`else
  logic w_step_unused;
  assign w_step_unused = bus.step;
  assign w_advance     = 1'b1;
`endif

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of its neighbours, matching real hardware.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_count <= '0;
      r_stim  <= '0;
      r_sig   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_pass  <= 1'b0;
    end else if (bus.abort) begin
      // Abort keeps stim and signature for post-mortem inspection.
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_pass  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            r_state <= S_RUN;
            r_count <= '0;
            r_stim  <= SEED_EFF;
            r_sig   <= '0;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
            r_pass  <= 1'b0;
          end
        end
        S_RUN: begin
          if (w_advance) begin
            r_sig   <= w_sig_next;
            r_stim  <= w_stim_next;
            r_count <= r_count + 16'd1;
            if (r_count == LAST_CNT) begin
              r_state <= S_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_pass  <= (w_sig_next == EXPECTED);
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_pass  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.stim      = r_stim;
  assign bus.signature = r_sig;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.pass      = r_pass;

endmodule
